// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single regfile write port among NUM_REQ writeback sources
//   (ALU, multdiv, load). The arbiter is round-robin, and each source has a
//   valid/ready handshake. The output stage is registered and drives the
//   regfile write port directly. Writes to r0 complete the handshake, but the
//   write enable is held low so the zero register is never written.
//
// Ports
//   clock            in   rising-edge system clock
//   ctrl_reset       in   synchronous, active-high reset
//   req_valid        in   [NUM_REQ]     requester i has a write pending
//   req_reg          in   [5*NUM_REQ]   destination register, bits [5i+4:5i]
//   req_data         in   [32*NUM_REQ]  write data, bits [32i+31:32i]
//   req_ready        out  [NUM_REQ]     one-hot combinational grant
//   ctrl_writeEnable out  registered regfile write enable
//   ctrl_writeReg    out  registered regfile write address
//   data_writeReg    out  registered regfile write data
//   grant_id         out  registered index of the source now on the port
//   wr_pending       out  copy of ctrl_writeEnable for hazard/forward logic
module regfile_write_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ID_W    = 2
) (
   input  logic                    clock,
   input  logic                    ctrl_reset,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [5*NUM_REQ-1:0]    req_reg,
   input  logic [32*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    ctrl_writeEnable,
   output logic [4:0]              ctrl_writeReg,
   output logic [31:0]             data_writeReg,
   output logic [ID_W-1:0]         grant_id,
   output logic                    wr_pending
);

   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] winner;
   logic [ID_W-1:0] next_ptr;
   logic            found;
   logic            grant;
   logic [4:0]      sel_reg;
   logic [31:0]     sel_data;

   // The wrapped scan from rr_ptr is split into two linear passes.
   // The first pass takes the lowest valid index at or above rr_ptr.
   // If nothing is found, the second pass takes the lowest valid index
   // overall, which must lie below rr_ptr.
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      sel_reg  = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!found && req_valid[i] && (i >= 32'(rr_ptr))) begin
            found    = 1'b1;
            winner   = ID_W'(i);
            sel_reg  = req_reg[5*i +: 5];
            sel_data = req_data[32*i +: 32];
         end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!found && req_valid[i]) begin
            found    = 1'b1;
            winner   = ID_W'(i);
            sel_reg  = req_reg[5*i +: 5];
            sel_data = req_data[32*i +: 32];
         end
      end
   end

   // A grant is suppressed while reset is asserted, so no handshake completes.
   assign grant = found && !ctrl_reset;

   always_comb begin
      req_ready = '0;
      if (grant) begin
         req_ready[winner] = 1'b1;
      end
   end

   assign next_ptr = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         rr_ptr           <= '0;
         ctrl_writeEnable <= 1'b0;
         ctrl_writeReg    <= '0;
         data_writeReg    <= '0;
         grant_id         <= '0;
      end else if (grant) begin
         rr_ptr           <= next_ptr;
         ctrl_writeEnable <= (sel_reg != 5'd0);
         ctrl_writeReg    <= sel_reg;
         data_writeReg    <= sel_data;
         grant_id         <= winner;
      end else begin
         ctrl_writeEnable <= 1'b0;
      end
   end

   assign wr_pending = ctrl_writeEnable;

endmodule
